// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: requester and result bus of the shared Booth multiplier
interface booth_mul_arbiter_if #(
  parameter int N = 8,
  parameter int R = 4,
  parameter int IDW = 2
);
  logic [R-1:0] req_valid;
  logic [R-1:0] req_ready;
  logic [R*N-1:0] req_x;
  logic [R*N-1:0] req_y;
  logic res_valid;
  logic res_ready;
  logic [2*N-1:0] res_p;
  logic [IDW-1:0] res_id;
  logic busy;
  logic [15:0] done_cnt;
  modport master (
    output req_valid, req_x, req_y, res_ready,
    input req_ready, res_valid, res_p, res_id, busy, done_cnt
  );
  modport slave (
    input req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_p, res_id, busy, done_cnt
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one radix-4 Booth multiplier behind a two-stage pipeline
module radix4acc #(
  parameter int N = 8
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);
  logic [N:0] yp;
  logic [2*N-1:0] xe;
  logic [2*N-1:0] m;
  logic [2*N-1:0] pp;
  logic [2:0] b;
  assign yp = {y, 1'b0};
  assign xe = {{N{x[N-1]}}, x};
  always_comb begin
    p = '0;
    b = '0;
    m = '0;
    pp = '0;
    for (int j = 0; j < N/2; j++) begin
      b = yp[2*j +: 3];
      m = (b[0] ^ b[1]) ? xe : (b == 3'b011 || b == 3'b100) ? xe << 1 : '0;
      pp = b[2] ? -m : m;
      p = p + (pp << (2*j));
    end
  end
endmodule

module booth_mul_arbiter #(
  parameter int N = 8,
  parameter int R = 4,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst,
  booth_mul_arbiter_if.slave bus
);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [N-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [IDW-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d, ptr_q, ptr_d, gnt_idx, idx;
  logic [2*N-1:0] s2_p_q, s2_p_d, prod;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic adv1, adv2, gnt_any, accept;
  radix4acc #(.N(N)) u_mul (.x(s1_x_q), .y(s1_y_q), .p(prod));
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    idx = ptr_q;
    for (int k = R; k >= 1; k--) begin
      idx = IDW'((int'(ptr_q) + k) % R);
      if (bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  always_comb begin
    adv2 = !s2_valid_q || bus.res_ready;
    adv1 = !s1_valid_q || adv2;
    accept = gnt_any && adv1 && !rst;
    s1_valid_d = adv1 ? accept : s1_valid_q;
    s1_x_d = accept ? bus.req_x[gnt_idx*N +: N] : s1_x_q;
    s1_y_d = accept ? bus.req_y[gnt_idx*N +: N] : s1_y_q;
    s1_id_d = accept ? gnt_idx : s1_id_q;
    ptr_d = accept ? gnt_idx : ptr_q;
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    s2_p_d = adv2 ? prod : s2_p_q;
    s2_id_d = adv2 ? s1_id_q : s2_id_q;
    done_cnt_d = done_cnt_q + 16'(s2_valid_q && bus.res_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      ptr_q <= IDW'(R - 1);
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      ptr_q <= ptr_d;
      done_cnt_q <= done_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    s1_x_q <= s1_x_d;
    s1_y_q <= s1_y_d;
    s1_id_q <= s1_id_d;
    s2_p_q <= s2_p_d;
    s2_id_q <= s2_id_d;
  end
  assign bus.req_ready = accept ? R'(1) << gnt_idx : '0;
  assign bus.res_valid = s2_valid_q;
  assign bus.res_p = s2_p_q;
  assign bus.res_id = s2_id_q;
  assign bus.busy = s1_valid_q || s2_valid_q;
  assign bus.done_cnt = done_cnt_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed self-checking bench for the shared Booth multiplier arbiter
module tb_booth_mul_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  booth_mul_arbiter_if #(.N(8), .R(4), .IDW(2)) bus();
  booth_mul_arbiter #(.N(8), .R(4), .IDW(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [7:0] x, input logic [7:0] y);
    bus.req_x[r*8 +: 8] = x;
    bus.req_y[r*8 +: 8] = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_done_cnt: got %h want 0000", bus.done_cnt); end
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_idle: got %b want 0000", bus.req_ready); end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 8'h7F, 8'h80);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_s1: got valid %b busy %b want 0 1", bus.res_valid, bus.busy); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_p !== 16'hC080 || bus.res_id !== 2'd0) begin n_fail++; $display("FAIL single_result: got v%b p=%h id=%0d want v1 p=c080 id=0", bus.res_valid, bus.res_p, bus.res_id); end
    n_cmp++; if (bus.done_cnt !== 16'd0) begin n_fail++; $display("FAIL single_cnt_before: got %0d want 0", bus.done_cnt); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.done_cnt !== 16'd1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got cnt %0d v%b busy %b want 1 0 0", bus.done_cnt, bus.res_valid, bus.busy); end
    tick();
  endtask

  task automatic test_corners();
    logic [7:0] xs [3] = '{8'h80, 8'hFF, 8'h00};
    logic [7:0] ys [3] = '{8'h80, 8'h01, 8'h5A};
    logic [15:0] ps [3] = '{16'h4000, 16'hFFFF, 16'h0000};
    int k = 0;
    int got = 0;
    do_reset();
    bus.res_ready = 1'b1;
    set_op(2, xs[0], ys[0]);
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 12 && got < 3; c++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        n_cmp++; if (bus.res_p !== ps[got] || bus.res_id !== 2'd2) begin n_fail++; $display("FAIL corner_%0d: got p=%h id=%0d want p=%h id=2", got, bus.res_p, bus.res_id, ps[got]); end
        got++;
      end
      if (bus.req_ready[2]) k++;
      tick();
      if (k < 3) set_op(2, xs[k], ys[k]); else bus.req_valid = '0;
    end
    n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL corner_count: got %0d want 3", got); end
  endtask

  task automatic test_sweep();
    int k = 0;
    int got = 0;
    logic [7:0] ex, ey;
    logic [15:0] w;
    do_reset();
    bus.res_ready = 1'b1;
    set_op(1, 8'h00, 8'h00);
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 65600 && got < 65536; c++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        ex = 8'(got >> 8);
        ey = 8'(got);
        w = 16'(int'($signed(ex)) * int'($signed(ey)));
        n_cmp++; if (bus.res_p !== w || bus.res_id !== 2'd1) begin n_fail++; $display("FAIL sweep x=%h y=%h: got p=%h id=%0d want p=%h id=1", ex, ey, bus.res_p, bus.res_id, w); end
        if (got == 65535) begin
          n_cmp++; if (bus.done_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_pre_wrap: got %h want ffff", bus.done_cnt); end
        end
        got++;
      end
      if (bus.req_ready[1]) k++;
      tick();
      if (k < 65536) set_op(1, 8'(k >> 8), 8'(k)); else bus.req_valid = '0;
    end
    n_cmp++; if (got !== 65536) begin n_fail++; $display("FAIL sweep_count: got %0d want 65536", got); end
    @(negedge clk);
    n_cmp++; if (bus.done_cnt !== 16'h0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL cnt_wrap: got cnt %h busy %b want 0000 0", bus.done_cnt, bus.busy); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'd3);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.req_ready, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'((c - 2) % 4) || bus.res_p !== 16'(((c - 2) % 4 + 1) * 3)) begin n_fail++; $display("FAIL rr_result c%0d: got v%b id=%0d p=%h want v1 id=%0d p=%h", c, bus.res_valid, bus.res_id, bus.res_p, (c - 2) % 4, 16'(((c - 2) % 4 + 1) * 3)); end
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    logic [15:0] w;
    do_reset();
    bus.res_ready = 1'b0;
    set_op(3, 8'd10, 8'hFD);
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready[3]) acc++;
      if (c >= 2) begin
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_p !== 16'hFFE2 || bus.res_id !== 2'd3) begin n_fail++; $display("FAIL bp_stall c%0d: got v%b p=%h id=%0d want v1 p=ffe2 id=3", c, bus.res_valid, bus.res_p, bus.res_id); end
      end
      tick();
      set_op(3, 8'(10 + acc), 8'hFD);
    end
    n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready: got %b want 0000", bus.req_ready); end
    tick();
    bus.res_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        w = 16'((10 + got) * -3);
        n_cmp++; if (bus.res_p !== w || bus.res_id !== 2'd3) begin n_fail++; $display("FAIL bp_order_%0d: got p=%h id=%0d want p=%h id=3", got, bus.res_p, bus.res_id, w); end
        got++;
      end
      if (bus.req_ready[3]) acc++;
      tick();
      if (acc < 6) set_op(3, 8'(10 + acc), 8'hFD); else bus.req_valid = '0;
    end
    n_cmp++; if (got !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", got); end
    @(negedge clk);
    n_cmp++; if (bus.done_cnt !== 16'd6 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_done: got cnt %0d busy %b want 6 0", bus.done_cnt, bus.busy); end
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [8] = '{4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
    do_reset();
    bus.res_ready = 1'b1;
    set_op(1, 8'd5, 8'd6);
    set_op(2, 8'd7, 8'd8);
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = (c % 2 == 0) ? 4'b0110 : 4'b0010;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== exp_g[c]) begin n_fail++; $display("FAIL fair_grant c%0d: got %b want %b", c, bus.req_ready, exp_g[c]); end
      tick();
    end
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL fair_idle c%0d: got %b want 0000", c, bus.req_ready); end
      tick();
    end
    bus.req_valid = 4'b0101;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL fair_ptr_hold: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 2), 8'd2);
    bus.req_valid = 4'b1111;
    repeat (4) tick();
    bus.res_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.done_cnt !== 16'd2) begin n_fail++; $display("FAIL mid_full: got busy %b v%b id=%0d cnt %0d want 1 1 2 2", bus.busy, bus.res_valid, bus.res_id, bus.done_cnt); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0000", bus.req_ready); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_after: got v%b busy %b cnt %0d want 0 0 0", bus.res_valid, bus.busy, bus.done_cnt); end
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", bus.req_ready); end
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale c%0d: got v%b want 0", c, bus.res_valid); end
    end
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_corners();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
